// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the intersection phase sequencer and
// the lamp driver.
//   phase_t    : sequencer state; the enum value is the PH phase code
//   LAMP_*     : 3-bit lamp codes used by the lamp-driver stage
package traffic_pkg;

    typedef enum logic [1:0] {
        S_HG = 2'd0,
        S_HY = 2'd1,
        S_FG = 2'd2,
        S_FY = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b110;
    localparam logic [2:0] LAMP_WHITE  = 3'b111;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable CW-bit down-counter with tick enable.
//   clk, rst  : clock, asynchronous active-high reset (loads RST_VAL)
//   load      : load load_val; has priority over tick
//   load_val  : value to load
//   tick      : decrement enable; the count saturates at zero
//   count     : current count
//   zero      : count == 0
module phase_timer #(
    parameter int CW      = 8,
    parameter int RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          zero
);

    localparam logic [CW-1:0] RST_CNT = CW'(RST_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_CNT;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: highway/farm-road phase sequencer.
//   Clk      : system clock, rising edge
//   RS       : asynchronous active-high reset
//   TICK     : timebase enable, one-cycle pulse per tick
//   FARMCAR  : farm-road vehicle sensor (latched)
//   AMB_IN   : farm-road ambulance request (latched; live level extends farm green)
//   HG/HY/HR : highway green/yellow/red phase strobes
//   FG/FY/FR : farm green/yellow/red phase strobes
//   PH       : current phase code (S_HG=0, S_HY=1, S_FG=2, S_FY=3)
//   REMAIN   : current phase timer value, in ticks
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CW     = 8,
    parameter int HG_MIN = 10,
    parameter int Y_T    = 3,
    parameter int FG_MIN = 3,
    parameter int FG_MAX = 8
) (
    input  logic          Clk,
    input  logic          RS,
    input  logic          TICK,
    input  logic          FARMCAR,
    input  logic          AMB_IN,
    output logic          HG,
    output logic          HY,
    output logic          HR,
    output logic          FG,
    output logic          FY,
    output logic          FR,
    output logic [1:0]    PH,
    output logic [CW-1:0] REMAIN
);

    if ((FG_MIN < 1) || (FG_MIN > FG_MAX) || (HG_MIN < 0) || (Y_T < 0) ||
        (HG_MIN >= 2**CW) || (Y_T >= 2**CW) || (FG_MAX >= 2**CW)) begin : g_param_err
        $error("traffic_phase_ctrl: illegal timing parameters");
    end

    localparam logic [CW-1:0] HG_LOAD   = CW'(HG_MIN);
    localparam logic [CW-1:0] Y_LOAD    = CW'(Y_T);
    localparam logic [CW-1:0] FG_LOAD   = CW'(FG_MAX);
    // Farm green may end early once the timer has fallen this far,
    // i.e. FG_MIN ticks have elapsed since the FG_MAX load.
    localparam logic [CW-1:0] EARLY_LIM = CW'(FG_MAX - FG_MIN);

    phase_t        state;
    phase_t        next_state;
    logic          farm_req;
    logic          amb_req;
    logic          timer_load;
    logic [CW-1:0] timer_load_val;
    logic [CW-1:0] timer;
    logic          timer_zero;
    logic          enter_fy;

    // state register and request latches
    always_ff @(posedge Clk or posedge RS) begin
        if (RS) begin
            state    <= S_HG;
            farm_req <= 1'b0;
            amb_req  <= 1'b0;
        end else begin
            state <= next_state;
            // a request present on the S_FY entry edge survives the clear
            if (FARMCAR) begin
                farm_req <= 1'b1;
            end else if (enter_fy) begin
                farm_req <= 1'b0;
            end
            if (AMB_IN) begin
                amb_req <= 1'b1;
            end else if (enter_fy) begin
                amb_req <= 1'b0;
            end
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_HG: if (amb_req || (timer_zero && farm_req)) next_state = S_HY;
            S_HY: if (timer_zero) next_state = S_FG;
            S_FG: if (!AMB_IN && (timer_zero || (!FARMCAR && (timer <= EARLY_LIM))))
                      next_state = S_FY;
            S_FY: if (timer_zero) next_state = S_HG;
            default: next_state = S_HG;
        endcase
    end

    assign enter_fy   = (state == S_FG) && (next_state == S_FY);
    assign timer_load = (next_state != state);

    always_comb begin
        timer_load_val = HG_LOAD;
        unique case (next_state)
            S_HG: timer_load_val = HG_LOAD;
            S_HY: timer_load_val = Y_LOAD;
            S_FG: timer_load_val = FG_LOAD;
            S_FY: timer_load_val = Y_LOAD;
            default: timer_load_val = HG_LOAD;
        endcase
    end

    phase_timer #(
        .CW      (CW),
        .RST_VAL (HG_MIN)
    ) u_timer (
        .clk      (Clk),
        .rst      (RS),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (TICK),
        .count    (timer),
        .zero     (timer_zero)
    );

    // output decode (Moore)
    always_comb begin
        HG = 1'b0;
        HY = 1'b0;
        HR = 1'b0;
        FG = 1'b0;
        FY = 1'b0;
        FR = 1'b0;
        unique case (state)
            S_HG: begin HG = 1'b1; FR = 1'b1; end
            S_HY: begin HY = 1'b1; FR = 1'b1; end
            S_FG: begin FG = 1'b1; HR = 1'b1; end
            S_FY: begin FY = 1'b1; HR = 1'b1; end
            default: begin HG = 1'b1; FR = 1'b1; end
        endcase
    end

    assign PH     = state;
    assign REMAIN = timer;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: randomized self-checking bench for traffic_phase_ctrl
// against a cycle-level behavioural model of the phase rules.
module tb_traffic_phase_ctrl;

    localparam int CW     = 8;
    localparam int HG_MIN = 10;
    localparam int Y_T    = 3;
    localparam int FG_MIN = 3;
    localparam int FG_MAX = 8;

    logic          Clk = 1'b0;
    logic          RS;
    logic          TICK;
    logic          FARMCAR;
    logic          AMB_IN;
    logic          HG, HY, HR, FG, FY, FR;
    logic [1:0]    PH;
    logic [CW-1:0] REMAIN;

    int n_vec  = 0;
    int n_miss = 0;

    // model state: phase index 0..3 (HG, HY, FG, FY), timer in ticks
    int m_ph;
    int m_t;
    bit m_farm;
    bit m_amb;
    int dur [4] = '{HG_MIN, Y_T, FG_MAX, Y_T};

    traffic_phase_ctrl #(
        .CW     (CW),
        .HG_MIN (HG_MIN),
        .Y_T    (Y_T),
        .FG_MIN (FG_MIN),
        .FG_MAX (FG_MAX)
    ) dut (
        .Clk     (Clk),
        .RS      (RS),
        .TICK    (TICK),
        .FARMCAR (FARMCAR),
        .AMB_IN  (AMB_IN),
        .HG      (HG),
        .HY      (HY),
        .HR      (HR),
        .FG      (FG),
        .FY      (FY),
        .FR      (FR),
        .PH      (PH),
        .REMAIN  (REMAIN)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_t    = HG_MIN;
        m_farm = 0;
        m_amb  = 0;
    endtask

    // one clock edge of the intersection rules, using the inputs seen at it
    task automatic model_step(input bit tick, input bit farm, input bit amb);
        bit go;
        int nph;
        case (m_ph)
            0:       go = m_amb || (m_t == 0 && m_farm);
            2:       go = !amb && (m_t == 0 || (!farm && m_t <= FG_MAX - FG_MIN));
            default: go = (m_t == 0);
        endcase
        nph = go ? (m_ph + 1) % 4 : m_ph;
        m_farm = farm ? 1'b1 : ((m_ph == 2 && go) ? 1'b0 : m_farm);
        m_amb  = amb  ? 1'b1 : ((m_ph == 2 && go) ? 1'b0 : m_amb);
        if (go)                 m_t = dur[nph];
        else if (tick && m_t > 0) m_t = m_t - 1;
        m_ph = nph;
    endtask

    task automatic check_outputs(input string tag);
        int exp_strobes;
        // strobe order {HG,HY,HR,FG,FY,FR}
        case (m_ph)
            0:       exp_strobes = 6'b100_001;
            1:       exp_strobes = 6'b010_001;
            2:       exp_strobes = 6'b001_100;
            default: exp_strobes = 6'b001_010;
        endcase
        check({tag, ".strobes"}, int'({HG, HY, HR, FG, FY, FR}), exp_strobes);
        check({tag, ".PH"}, int'(PH), m_ph);
        check({tag, ".REMAIN"}, int'(REMAIN), m_t);
    endtask

    // drive random inputs for one cycle, clock it, then compare
    int amb_left = 0;
    int cyc      = 0;

    task automatic run_cycle(input int tick_mode, input int farm_pct, input int amb_pct);
        TICK = (tick_mode == 0) ? 1'b1 :
               (tick_mode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(1, 0));
        FARMCAR = ($urandom_range(99, 0) < farm_pct);
        if (amb_left == 0 && $urandom_range(99, 0) < amb_pct)
            amb_left = $urandom_range(20, 1);
        AMB_IN = (amb_left > 0);
        if (amb_left > 0) amb_left--;
        @(posedge Clk);
        model_step(TICK, FARMCAR, AMB_IN);
        cyc++;
        #1;
        check_outputs("run");
    endtask

    initial begin
        bit reached;
        RS = 1'b1; TICK = 1'b0; FARMCAR = 1'b0; AMB_IN = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge Clk);
        #1;
        RS = 1'b0;

        // idle highway: must sit in HG with the timer saturated at zero
        for (int i = 0; i < 50; i++) run_cycle(0, 0, 0);

        // mixed traffic with several tick densities and request rates
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 300; i++) run_cycle(m, 5, 0);
            for (int i = 0; i < 300; i++) run_cycle(m, 60, 0);
            for (int i = 0; i < 300; i++) run_cycle(m, 8, 4);
        end

        // asynchronous reset in the middle of farm green
        reached = 0;
        for (int i = 0; i < 400 && !reached; i++) begin
            run_cycle(0, 30, 2);
            reached = (m_ph == 2);
        end
        check("reach_fg", int'(reached), 1);
        TICK = 1'b1; FARMCAR = 1'b0; AMB_IN = 1'b0; amb_left = 0;
        #2;
        RS = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge Clk);
        #1;
        check_outputs("rst_held");
        RS = 1'b0;
        // latches were cleared: no phase change without a fresh request
        for (int i = 0; i < 40; i++) run_cycle(0, 0, 0);
        for (int i = 0; i < 300; i++) run_cycle(2, 10, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
